ctrl_sequencer: RTL

Hardwired control unit that drives the datapath's control inputs for fetch and for register-register ALU, multiply/divide, unary and halt instructions. It produces the Rin/Rout/PCin/MARin/MDRin/IRin/Yin/Z*/HI/LO/ALUop/Read strobes that benches currently hand-sequence. It takes the IR contents and a memory-ready handshake back from the datapath. It sits beside the datapath at CPU top level.

---
 rtl/ctrl_sequencer_if.sv | 33 +++
 rtl/ctrl_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer_if.sv
// Control-unit <-> datapath bundle: IR/handshake toward the sequencer,
// control strobes toward the datapath.
interface ctrl_sequencer_if #(
    parameter int RW = 4
);
    localparam int NR = 1 << RW;

    logic          run;
    logic [31:0]   IR;
    logic          mem_ready;

    logic [NR-1:0] Rin;
    logic [NR-1:0] Rout;
    logic          PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin;
    logic          Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic          Read;
    logic [3:0]    ALUop;
    logic          instr_done, halted, illegal;

    modport master (
        input  run, IR, mem_ready,
        output Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin,
               Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Read, ALUop,
               instr_done, halted, illegal
    );

    modport slave (
        output run, IR, mem_ready,
        input  Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin,
               Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Read, ALUop,
               instr_done, halted, illegal
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) then execute (T3-T6) for
// register-register ALU, MUL/DIV, NEG/NOT and HALT instructions.
module ctrl_sequencer #(
    parameter int OPW = 5,
    parameter int RW  = 4
) (
    input  logic             clock,
    input  logic             clear,
    ctrl_sequencer_if.master bus
);
    localparam int NR    = 1 << RW;
    localparam int RA_HI = 31 - OPW;

    typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, HALT} state_t;

    state_t         r_state;

    logic [OPW-1:0] w_op;
    logic [RW-1:0]  w_ra, w_rb, w_rc;
    logic [NR-1:0]  w_ra_oh, w_rb_oh, w_rc_oh;
    logic [3:0]     w_aluop;
    logic           w_is_bin, w_is_muldiv, w_is_unary, w_is_halt;
    logic           w_unused;
    state_t         w_end_next;

    assign w_op     = bus.IR[31 -: OPW];
    assign w_ra     = bus.IR[RA_HI -: RW];
    assign w_rb     = bus.IR[RA_HI - RW -: RW];
    assign w_rc     = bus.IR[RA_HI - 2*RW -: RW];
    assign w_unused = ^bus.IR[RA_HI - 3*RW : 0];

    assign w_ra_oh  = NR'(1) << w_ra;
    assign w_rb_oh  = NR'(1) << w_rb;
    assign w_rc_oh  = NR'(1) << w_rc;
    assign w_aluop  = w_op[3:0];

    assign w_is_bin    = (w_op <= OPW'(8));
    assign w_is_muldiv = (w_op == OPW'(9))  || (w_op == OPW'(10));
    assign w_is_unary  = (w_op == OPW'(11)) || (w_op == OPW'(12));
    assign w_is_halt   = &w_op;

    assign w_end_next  = bus.run ? T0 : IDLE;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: if (bus.run) r_state <= T0;
                T0:   r_state <= T1;
                T1:   if (bus.mem_ready) r_state <= T2;
                T2:   r_state <= T3;
                T3: begin
                    if (w_is_halt)                     r_state <= HALT;
                    else if (w_is_bin || w_is_muldiv)  r_state <= T4;
                    else if (w_is_unary)               r_state <= T5;
                    else                               r_state <= w_end_next;
                end
                T4:   r_state <= T5;
                T5:   r_state <= w_is_muldiv ? T6 : w_end_next;
                T6:   r_state <= w_end_next;
                HALT: r_state <= HALT;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Strobes are decoded from r_state and the live IR rather than registered:
    // IR is only loaded on the T2->T3 edge, so T3 strobes cannot be precomputed.
    // The async clear forces IDLE, which decodes to all-zero outputs.
    always_comb begin
        bus.Rin        = '0;
        bus.Rout       = '0;
        bus.PCin       = 1'b0;
        bus.PCout      = 1'b0;
        bus.IncPC      = 1'b0;
        bus.MARin      = 1'b0;
        bus.MDRin      = 1'b0;
        bus.MDRout     = 1'b0;
        bus.IRin       = 1'b0;
        bus.Yin        = 1'b0;
        bus.Zlowin     = 1'b0;
        bus.Zhighin    = 1'b0;
        bus.Zlowout    = 1'b0;
        bus.Zhighout   = 1'b0;
        bus.HIin       = 1'b0;
        bus.LOin       = 1'b0;
        bus.Read       = 1'b0;
        bus.ALUop      = '0;
        bus.instr_done = 1'b0;
        bus.halted     = 1'b0;
        bus.illegal    = 1'b0;
        case (r_state)
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
            end
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            T3: begin
                if (w_is_bin || w_is_muldiv) begin
                    bus.Rout = w_rb_oh;
                    bus.Yin  = 1'b1;
                end else if (w_is_unary) begin
                    bus.Rout   = w_rb_oh;
                    bus.ALUop  = w_aluop;
                    bus.Zlowin = 1'b1;
                end else if (w_is_halt) begin
                    bus.instr_done = 1'b1;
                end else begin
                    bus.instr_done = 1'b1;
                    bus.illegal    = 1'b1;
                end
            end
            T4: begin
                bus.Rout    = w_rc_oh;
                bus.ALUop   = w_aluop;
                bus.Zlowin  = 1'b1;
                bus.Zhighin = w_is_muldiv;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                if (w_is_muldiv) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.Rin        = w_ra_oh;
                    bus.instr_done = 1'b1;
                end
            end
            T6: begin
                bus.Zhighout   = 1'b1;
                bus.HIin       = 1'b1;
                bus.instr_done = 1'b1;
            end
            HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end
endmodule
